// File: rtl/pkt_train_scheduler.sv
// Gates a 256-bit AXI4-Stream so that exactly one configured train of packets,
// separated by a programmable idle gap, reaches the timestamp insertion stage.
module pkt_train_scheduler #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int TRAIN_LEN_WIDTH    = 16,
    parameter int GAP_WIDTH          = 32
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             cfg_start,
    input  logic                             cfg_abort,
    input  logic [TRAIN_LEN_WIDTH-1:0]       cfg_train_len,
    input  logic [GAP_WIDTH-1:0]             cfg_gap_cycles,
    output logic                             status_busy,
    output logic                             status_done,
    output logic                             status_aborted,
    output logic [TRAIN_LEN_WIDTH-1:0]       status_pkt_count,
    output logic                             pkt_start,
    input  logic [C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
    input  logic                             s_axis_tvalid,
    input  logic                             s_axis_tlast,
    output logic                             s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
    output logic                             m_axis_tvalid,
    output logic                             m_axis_tlast,
    input  logic                             m_axis_tready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_PKT,
        S_SEND,
        S_GAP,
        S_FINISH
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [TRAIN_LEN_WIDTH-1:0] len_q;
    logic [TRAIN_LEN_WIDTH-1:0] pkt_count;
    logic [TRAIN_LEN_WIDTH-1:0] count_inc;
    logic [GAP_WIDTH-1:0]       gap_q;
    logic [GAP_WIDTH-1:0]       gap_cnt;
    logic                       busy;
    logic                       done;
    logic                       aborted;
    logic                       abort_pending;
    logic                       pkt_start_q;
    logic                       gate;
    logic                       beat_hs;
    logic                       last_hs;
    logic                       stop_after;

    // An abort in WAIT_PKT closes the gate in the same cycle so no first beat slips out.
    assign gate       = (state == S_SEND) || ((state == S_WAIT_PKT) && !cfg_abort);
    assign beat_hs    = s_axis_tvalid && m_axis_tready && gate;
    assign last_hs    = beat_hs && s_axis_tlast;
    assign count_inc  = pkt_count + 1'b1;
    assign stop_after = (count_inc == len_q) || abort_pending || cfg_abort;

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tstrb  = s_axis_tstrb;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tvalid = s_axis_tvalid && gate;
    assign s_axis_tready = m_axis_tready && gate;

    assign status_busy      = busy;
    assign status_done      = done;
    assign status_aborted   = aborted;
    assign status_pkt_count = pkt_count;
    assign pkt_start        = pkt_start_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    state_next = (cfg_train_len == '0) ? S_FINISH : S_WAIT_PKT;
                end
            end
            S_WAIT_PKT, S_SEND: begin
                if ((state == S_WAIT_PKT) && cfg_abort) begin
                    state_next = S_FINISH;
                end else if (last_hs) begin
                    if (stop_after) begin
                        state_next = S_FINISH;
                    end else if (gap_q == '0) begin
                        state_next = S_WAIT_PKT;
                    end else begin
                        state_next = S_GAP;
                    end
                end else if (beat_hs) begin
                    state_next = S_SEND;
                end
            end
            S_GAP: begin
                if (cfg_abort) begin
                    state_next = S_FINISH;
                end else if (gap_cnt == GAP_WIDTH'(1)) begin
                    state_next = S_WAIT_PKT;
                end
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            len_q         <= '0;
            gap_q         <= '0;
            gap_cnt       <= '0;
            pkt_count     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            abort_pending <= 1'b0;
            pkt_start_q   <= 1'b0;
        end else begin
            pkt_start_q <= (state == S_WAIT_PKT) && beat_hs;
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        len_q         <= cfg_train_len;
                        gap_q         <= cfg_gap_cycles;
                        pkt_count     <= '0;
                        done          <= 1'b0;
                        aborted       <= 1'b0;
                        abort_pending <= 1'b0;
                        busy          <= 1'b1;
                    end
                end
                S_WAIT_PKT, S_SEND: begin
                    if (last_hs) begin
                        pkt_count <= count_inc;
                        gap_cnt   <= gap_q;
                    end
                    if (cfg_abort) begin
                        abort_pending <= 1'b1;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    if (cfg_abort) begin
                        abort_pending <= 1'b1;
                    end
                end
                S_FINISH: begin
                    busy          <= 1'b0;
                    done          <= 1'b1;
                    aborted       <= abort_pending;
                    abort_pending <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_train_scheduler.sv
// Directed bench for pkt_train_scheduler: a bench-side packet source feeds the
// DUT while handshakes and pkt_start pulses are logged against hand-computed cycles.
module tb_pkt_train_scheduler;

    logic         clk;
    logic         resetn;
    logic         cfg_start;
    logic         cfg_abort;
    logic [15:0]  cfg_train_len;
    logic [31:0]  cfg_gap_cycles;
    logic         status_busy;
    logic         status_done;
    logic         status_aborted;
    logic [15:0]  status_pkt_count;
    logic         pkt_start;
    logic [255:0] s_axis_tdata;
    logic [127:0] s_axis_tuser;
    logic [31:0]  s_axis_tstrb;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [127:0] m_axis_tuser;
    logic [31:0]  m_axis_tstrb;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;

    int           checks;
    int           errors;
    int           cyc;
    int           pulses;
    int           done_cyc;
    int           src_len;
    int           src_beat;
    logic         src_en;
    logic         tready_toggle;
    logic [31:0]  src_word;
    logic [31:0]  base;
    logic [31:0]  hs_q[$];
    int           hs_cyc[$];
    int           ps_cyc[$];

    pkt_train_scheduler dut (
        .clk              (clk),
        .resetn           (resetn),
        .cfg_start        (cfg_start),
        .cfg_abort        (cfg_abort),
        .cfg_train_len    (cfg_train_len),
        .cfg_gap_cycles   (cfg_gap_cycles),
        .status_busy      (status_busy),
        .status_done      (status_done),
        .status_aborted   (status_aborted),
        .status_pkt_count (status_pkt_count),
        .pkt_start        (pkt_start),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tuser     (s_axis_tuser),
        .s_axis_tstrb     (s_axis_tstrb),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tready    (s_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tuser     (m_axis_tuser),
        .m_axis_tstrb     (m_axis_tstrb),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tready    (m_axis_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int cyc_at(input int i);
        if (i < hs_cyc.size()) return hs_cyc[i];
        return -1000;
    endfunction

    task automatic drive_source();
        s_axis_tvalid = src_en;
        s_axis_tdata  = {8{src_word}};
        s_axis_tuser  = {4{~src_word}};
        s_axis_tstrb  = src_word;
        s_axis_tlast  = (src_beat == src_len - 1);
    endtask

    task automatic clear_logs();
        hs_q.delete();
        hs_cyc.delete();
        ps_cyc.delete();
        pulses = 0;
    endtask

    // One clock: log this cycle's handshake and strobe, then drive the next cycle's inputs.
    task automatic run_cycle();
        #1;
        if (m_axis_tvalid && m_axis_tready) begin
            hs_q.push_back(m_axis_tdata[31:0]);
            hs_cyc.push_back(cyc);
        end
        if (s_axis_tvalid && s_axis_tready) begin
            src_word = src_word + 1;
            src_beat = s_axis_tlast ? 0 : src_beat + 1;
        end
        if (pkt_start) begin
            pulses++;
            ps_cyc.push_back(cyc);
        end
        @(negedge clk);
        cyc++;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        if (tready_toggle) m_axis_tready = ~m_axis_tready;
        drive_source();
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int n = 0;
        while (!status_done && n < max_cycles) begin
            run_cycle();
            n++;
        end
        done_cyc = cyc;
        check_output({tag, "_done_in_time"}, 32'(status_done), 32'd1);
    endtask

    task automatic apply_stimulus(input int len, input int gap, input int beats);
        clear_logs();
        cfg_train_len  = 16'(len);
        cfg_gap_cycles = 32'(gap);
        src_len        = beats;
        drive_source();
        base           = src_word;
        cfg_start      = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; pulses = 0; done_cyc = 0;
        resetn = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
        cfg_train_len = '0; cfg_gap_cycles = '0;
        src_en = 1'b1; src_len = 2; src_beat = 0; src_word = 32'h100;
        tready_toggle = 1'b0; m_axis_tready = 1'b1; base = '0;
        drive_source();

        #1;
        check_output("rst_busy", 32'(status_busy), 32'd0);
        check_output("rst_pkt_count", 32'(status_pkt_count), 32'd0);
        check_output("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_cycle();
        run_cycle();
        #1;
        check_output("idle_done", 32'(status_done), 32'd0);
        check_output("idle_aborted", 32'(status_aborted), 32'd0);
        check_output("idle_pkt_start", 32'(pkt_start), 32'd0);
        check_output("idle_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_output("idle_tready", 32'(s_axis_tready), 32'd0);
        check_output("pass_tdata", 32'(m_axis_tdata === s_axis_tdata), 32'd1);
        check_output("pass_tuser_tstrb", 32'((m_axis_tuser === s_axis_tuser) && (m_axis_tstrb === s_axis_tstrb)), 32'd1);
        check_output("idle_no_hs", 32'(hs_q.size()), 32'd0);

        $display("[TB] basic train len=3 gap=4");
        apply_stimulus(3, 4, 2);
        run_cycle();
        check_output("t1_busy", 32'(status_busy), 32'd1);
        wait_done("t1", 60);
        check_output("t1_beats", 32'(hs_q.size()), 32'd6);
        check_output("t1_spacing_a", 32'(cyc_at(2) - cyc_at(0)), 32'd6);
        check_output("t1_spacing_b", 32'(cyc_at(4) - cyc_at(2)), 32'd6);
        check_output("t1_pulses", 32'(pulses), 32'd3);
        check_output("t1_pulse_timing", 32'((ps_cyc.size() > 0) && (ps_cyc[0] == cyc_at(0) + 1)), 32'd1);
        check_output("t1_pkt_count", 32'(status_pkt_count), 32'd3);
        check_output("t1_done_latency", 32'(done_cyc - cyc_at(5)), 32'd2);
        check_output("t1_busy_end", 32'(status_busy), 32'd0);
        check_output("t1_aborted", 32'(status_aborted), 32'd0);

        $display("[TB] zero length train");
        apply_stimulus(0, 3, 2);
        run_cycle();
        check_output("t2_done_cleared", 32'(status_done), 32'd0);
        check_output("t2_busy", 32'(status_busy), 32'd1);
        run_cycle();
        check_output("t2_done", 32'(status_done), 32'd1);
        check_output("t2_busy_end", 32'(status_busy), 32'd0);
        check_output("t2_pkt_count", 32'(status_pkt_count), 32'd0);
        check_output("t2_no_beats", 32'(hs_q.size()), 32'd0);

        $display("[TB] gap zero single-beat packets");
        apply_stimulus(4, 0, 1);
        run_cycle();
        wait_done("t3", 30);
        check_output("t3_beats", 32'(hs_q.size()), 32'd4);
        check_output("t3_back_to_back", 32'(cyc_at(3) - cyc_at(0)), 32'd3);
        check_output("t3_pulses", 32'(pulses), 32'd4);
        check_output("t3_pkt_count", 32'(status_pkt_count), 32'd4);

        $display("[TB] backpressure len=2 gap=2");
        tready_toggle = 1'b1;
        apply_stimulus(2, 2, 4);
        run_cycle();
        wait_done("t4", 80);
        tready_toggle = 1'b0;
        m_axis_tready = 1'b1;
        check_output("t4_beats", 32'(hs_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("t4_order_%0d", i), (i < hs_q.size()) ? hs_q[i] : 32'hdead, base + 32'(i));
        end
        check_output("t4_gap_from_tlast", 32'(cyc_at(4) - cyc_at(3)), 32'd4);
        check_output("t4_pulses", 32'(pulses), 32'd2);
        check_output("t4_pkt_count", 32'(status_pkt_count), 32'd2);

        $display("[TB] abort in SEND");
        apply_stimulus(5, 1, 4);
        run_cycle();
        run_cycle();
        cfg_abort = 1'b1;
        run_cycle();
        wait_done("t5", 30);
        for (int i = 0; i < 5; i++) run_cycle();
        check_output("t5_beats", 32'(hs_q.size()), 32'd4);
        check_output("t5_last_beat", (hs_q.size() > 3) ? hs_q[3] : 32'hdead, base + 32'd3);
        check_output("t5_pkt_count", 32'(status_pkt_count), 32'd1);
        check_output("t5_aborted", 32'(status_aborted), 32'd1);
        check_output("t5_pulses", 32'(pulses), 32'd1);

        $display("[TB] abort in GAP");
        apply_stimulus(3, 5, 1);
        run_cycle();
        run_cycle();
        run_cycle();
        cfg_abort = 1'b1;
        run_cycle();
        check_output("t6_finish_busy", 32'(status_busy), 32'd1);
        check_output("t6_finish_done", 32'(status_done), 32'd0);
        run_cycle();
        check_output("t6_done", 32'(status_done), 32'd1);
        check_output("t6_aborted", 32'(status_aborted), 32'd1);
        check_output("t6_busy_end", 32'(status_busy), 32'd0);
        check_output("t6_pkt_count", 32'(status_pkt_count), 32'd1);
        check_output("t6_beats", 32'(hs_q.size()), 32'd1);

        $display("[TB] start while busy");
        apply_stimulus(2, 3, 1);
        run_cycle();
        run_cycle();
        cfg_start      = 1'b1;
        cfg_train_len  = 16'd7;
        cfg_gap_cycles = 32'd0;
        run_cycle();
        wait_done("t7", 40);
        for (int i = 0; i < 4; i++) run_cycle();
        check_output("t7_beats", 32'(hs_q.size()), 32'd2);
        check_output("t7_latched_gap", 32'(cyc_at(1) - cyc_at(0)), 32'd4);
        check_output("t7_pkt_count", 32'(status_pkt_count), 32'd2);
        check_output("t7_aborted_cleared", 32'(status_aborted), 32'd0);
        check_output("t7_not_restarted", 32'(status_busy), 32'd0);

        $display("[TB] reset pulse mid-packet");
        apply_stimulus(2, 0, 4);
        run_cycle();
        run_cycle();
        #1;
        check_output("t8_pre_pkt_start", 32'(pkt_start), 32'd1);
        check_output("t8_pre_tvalid", 32'(m_axis_tvalid), 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        check_output("t8_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_output("t8_rst_tready", 32'(s_axis_tready), 32'd0);
        check_output("t8_rst_busy", 32'(status_busy), 32'd0);
        check_output("t8_rst_pkt_start", 32'(pkt_start), 32'd0);
        check_output("t8_rst_pkt_count", 32'(status_pkt_count), 32'd0);
        @(negedge clk);
        cyc++;
        resetn   = 1'b1;
        src_beat = 0;
        apply_stimulus(2, 0, 2);
        run_cycle();
        wait_done("t8", 30);
        check_output("t8_beats", 32'(hs_q.size()), 32'd4);
        check_output("t8_pulses", 32'(pulses), 32'd2);
        check_output("t8_pkt_count", 32'(status_pkt_count), 32'd2);
        check_output("t8_aborted", 32'(status_aborted), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
